// File: rtl/share_decoder_pkg.sv
// share_decoder_pkg: share-count, default widths and handshake helper for the 2-share unmasking path
package share_decoder_pkg;
  localparam int NSHARES = 2;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;
  typedef logic [NSHARES-1:0][DEF_WIDTH-1:0] share_vec_t;
  function automatic logic fire(input logic valid, input logic ready);
    return valid & ready;
  endfunction
endpackage

// File: rtl/share_decoder_if.sv
// share_decoder_if: masked-share input and plain-word output valid/ready channels
interface share_decoder_if #(parameter int WIDTH = share_decoder_pkg::DEF_WIDTH);
  logic in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] in_s0, in_s1, out_data;
  modport master (output in_valid, in_s0, in_s1, out_ready, input in_ready, out_valid, out_data);
  modport slave (input in_valid, in_s0, in_s1, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/share_decoder_pipe_stage.sv
// share_pipe_stage: one-entry valid/ready register stage with synchronous flush
module share_pipe_stage
  import share_decoder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         ready_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic         adv_o
);
  logic v_q, v_d, take;
  logic [W-1:0] data_q, data_d;
  always_comb begin
    ready_o = ~v_q | ready_i;
    take = fire(valid_i, ready_o);
    adv_o = fire(v_q, ready_i);
    v_d = flush_i ? 1'b0 : take ? 1'b1 : adv_o ? 1'b0 : v_q;
    data_d = flush_i ? '0 : take ? data_i : data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= 1'b0;
      data_q <= '0;
    end else begin
      v_q <= v_d;
      data_q <= data_d;
    end
  end
  assign valid_o = v_q;
  assign data_o = data_q;
endmodule

// File: rtl/share_decoder.sv
// share_decoder: registers both shares apart, then recombines them into the plain word
module share_decoder
  import share_decoder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               zeroize,
  share_decoder_if.slave     bus,
  output logic [CNT_W-1:0]   word_cnt
);
  logic [NSHARES-1:0][WIDTH-1:0] shares_in, shares_r;
  logic [WIDTH-1:0] plain;
  logic v1, s1_rdy, s2_rdy, deliver, in_go;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign shares_in = {bus.in_s1, bus.in_s0};
  assign in_go = rst_n & ~zeroize;
  assign bus.in_ready = in_go & s1_rdy;
  // shares only meet here, after both have settled in separate flops
  assign plain = shares_r[0] ^ shares_r[1];
  share_pipe_stage #(.W(NSHARES*WIDTH)) u_stage1 (
    .clk(clk), .rst_n(rst_n), .flush_i(zeroize),
    .valid_i(bus.in_valid & in_go), .data_i(shares_in), .ready_o(s1_rdy),
    .valid_o(v1), .ready_i(s2_rdy), .data_o(shares_r), .adv_o()
  );
  share_pipe_stage #(.W(WIDTH)) u_stage2 (
    .clk(clk), .rst_n(rst_n), .flush_i(zeroize),
    .valid_i(v1), .data_i(plain), .ready_o(s2_rdy),
    .valid_o(bus.out_valid), .ready_i(bus.out_ready), .data_o(bus.out_data), .adv_o(deliver)
  );
  assign cnt_d = cnt_q + CNT_W'(deliver);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign word_cnt = cnt_q;
endmodule

// File: tb/tb_share_decoder.sv
// tb_share_decoder: table vectors, corner sequences and random traffic against a queue model
module tb_share_decoder;
  localparam int W = 8;
  logic clk = 1'b0, rst_n = 1'b0, zeroize = 1'b0;
  logic [15:0] wc;
  logic [1:0] wc2;
  share_decoder_if #(.WIDTH(W)) bus();
  share_decoder_if #(.WIDTH(W)) bus2();
  assign bus2.in_valid = bus.in_valid;
  assign bus2.in_s0 = bus.in_s0;
  assign bus2.in_s1 = bus.in_s1;
  assign bus2.out_ready = bus.out_ready;
  share_decoder #(.WIDTH(W), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .zeroize(zeroize), .bus(bus.slave), .word_cnt(wc));
  share_decoder #(.WIDTH(W), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .zeroize(zeroize), .bus(bus2.slave), .word_cnt(wc2));
  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] w; int t; } ent_t;
  typedef struct { logic v; logic [W-1:0] s0, s1; logic ordy; logic ev; logic [W-1:0] ed; int ec; } vec_t;
  ent_t q[$];
  int edge_n = 0, total = 0, bad = 0;
  logic [31:0] cnt = 0;
  logic last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Entered and left at posedge+1; checks at the falling edge, then advances the model on the rising edge.
  task automatic cyc(input logic v, input logic [W-1:0] s0, input logic [W-1:0] s1, input logic ordy,
                     input logic z, input logic ten, input logic ev, input logic [W-1:0] ed, input int ec);
    logic hv, adv, rdy;
    int s1n;
    bus.in_valid = v; bus.in_s0 = s0; bus.in_s1 = s1; bus.out_ready = ordy; zeroize = z;
    #4;
    hv = q.size() > 0 && edge_n >= q[0].t + 2;
    s1n = q.size() - (hv ? 1 : 0);
    adv = s1n > 0 && (!hv || ordy);
    rdy = !z && (s1n == 0 || adv);
    chk("in_ready", 32'(bus.in_ready), 32'(rdy));
    chk("out_valid", 32'(bus.out_valid), 32'(hv));
    chk("out_valid_w2", 32'(bus2.out_valid), 32'(hv));
    if (hv) begin
      chk("out_data", 32'(bus.out_data), 32'(q[0].w));
      chk("out_data_w2", 32'(bus2.out_data), 32'(q[0].w));
    end
    chk("word_cnt", 32'(wc), 32'(cnt[15:0]));
    chk("word_cnt_w2", 32'(wc2), 32'(cnt[1:0]));
    if (ten) begin
      chk("tbl_out_valid", 32'(bus.out_valid), 32'(ev));
      if (ev) chk("tbl_out_data", 32'(bus.out_data), 32'(ed));
      chk("tbl_word_cnt", 32'(wc), 32'(ec));
    end
    last_acc = v && rdy;
    @(posedge clk);
    if (hv && ordy) begin
      void'(q.pop_front());
      cnt++;
    end
    if (last_acc) q.push_back('{w: s0 ^ s1, t: edge_n});
    if (z) q.delete();
    edge_n++;
    #1;
  endtask

  task automatic c(input logic v, input logic [W-1:0] s0, input logic [W-1:0] s1, input logic ordy, input logic z);
    cyc(v, s0, s1, ordy, z, 1'b0, 1'b0, '0, 0);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_word_cnt", 32'(wc), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    q.delete();
    cnt = 0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; zeroize = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t tbl[4];
    logic [W-1:0] bw[4];
    logic [1:0] seq[5];
    logic [15:0] wsave;
    int n;
    tbl[0] = '{1'b1, 8'hA5, 8'h3C, 1'b1, 1'b0, 8'h00, 0};
    tbl[1] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 0};
    tbl[2] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h99, 0};
    tbl[3] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1};
    bw = '{8'h11, 8'h22, 8'h33, 8'h44};
    seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    bus.in_valid = 1'b0; bus.in_s0 = '0; bus.in_s1 = '0; bus.out_ready = 1'b0;
    #1;
    do_reset();
    for (int i = 0; i < 4; i++) cyc(tbl[i].v, tbl[i].s0, tbl[i].s1, tbl[i].ordy, 1'b0, 1'b1, tbl[i].ev, tbl[i].ed, tbl[i].ec);
    for (int i = 0; i < 16; i++) c(1'b1, W'(i), 8'h5A, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) c(1'b0, '0, '0, 1'b1, 1'b0);
    n = 0;
    for (int k = 0; k < 5; k++) begin
      c(n < 4, bw[n % 4], 8'h0F, 1'b0, 1'b0);
      if (last_acc) n++;
    end
    chk("bp_accepts", 32'(n), 2);
    for (int k = 0; k < 12; k++) begin
      c(n < 4, bw[n % 4], 8'h0F, 1'b1, 1'b0);
      if (last_acc) n++;
    end
    chk("bp_all_accepted", 32'(n), 4);
    chk("bp_drained", 32'(bus.out_valid), 0);
    c(1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
    c(1'b1, 8'h56, 8'h78, 1'b0, 1'b0);
    c(1'b0, '0, '0, 1'b0, 1'b0);
    wsave = wc;
    c(1'b1, 8'h9A, 8'hBC, 1'b0, 1'b1);
    chk("zero_out_valid", 32'(bus.out_valid), 0);
    chk("zero_out_data", 32'(bus.out_data), 0);
    chk("zero_word_cnt", 32'(wc), 32'(wsave));
    c(1'b0, '0, '0, 1'b1, 1'b0);
    c(1'b1, 8'hF0, 8'h0F, 1'b1, 1'b0);
    c(1'b1, 8'hE1, 8'h1E, 1'b0, 1'b0);
    c(1'b0, '0, '0, 1'b0, 1'b0);
    do_reset();
    cyc(1'b1, 8'hC3, 8'h0F, 1'b1, 1'b0, 1'b1, 1'b0, '0, 0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b0, '0, 0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hCC, 0);
    do_reset();
    for (int k = 0; k < 7; k++) begin
      c(k < 5, W'(k), 8'h00, 1'b1, 1'b0);
      if (k >= 2) chk("wrap_cnt2", 32'(wc2), 32'(seq[k-2]));
    end
    for (int k = 0; k < 400; k++)
      c($urandom % 4 != 0, W'($urandom), W'($urandom), $urandom % 3 != 0, $urandom % 32 == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
